alu_unit: RTL and testbench

//   Parameterised N-bit ALU: add/sub with carry, bitwise logic, and logical/arithmetic shifts.

---
 rtl/alu_ops.sv | 16 +
 rtl/alu_unit.sv | 104 ++++++++++
 tb/tb_alu_unit.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ops.sv
// Opcode encodings shared by the execute-stage ALU and anything that issues to it.
package alu_ops;

    typedef logic [3:0] opcode_t;

    localparam opcode_t ADD_OP      = 4'h0;
    localparam opcode_t SUB_OP      = 4'h1;
    localparam opcode_t AND_OP      = 4'h2;
    localparam opcode_t OR_OP       = 4'h3;
    localparam opcode_t XOR_OP      = 4'h4;
    localparam opcode_t NOT_OP      = 4'h5;
    localparam opcode_t LL_SHIFT_OP = 4'h6;
    localparam opcode_t LR_SHIFT_OP = 4'h7;
    localparam opcode_t AR_SHIFT_OP = 4'h8;

endpackage : alu_ops

// File: rtl/alu_unit.sv
// N-bit execute-stage ALU: add/sub, bitwise logic and shifts, with NZCV flags.
// Result and flags are registered, giving one clock of latency at full throughput.
module alu_unit
    import alu_ops::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   opcode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] y,
    output logic         cout,
    output logic         overflow,
    output logic         negative,
    output logic         zero
);

    logic [N-1:0] y_d, y_q;
    logic         cout_d, cout_q;
    logic         overflow_d, overflow_q;
    logic         negative_d, negative_q;
    logic         zero_d, zero_q;

    logic               is_sub;
    logic [N-1:0]       add_b;
    logic               add_c;
    logic [N:0]         sum;
    logic [N:0]         ll_ext;
    logic [N:0]         lr_ext;
    logic signed [N:0]  ar_ext;

    // SUB reuses the adder as a + ~b + !cin, so carry-out reads as "no borrow".
    assign is_sub = (opcode == SUB_OP);
    assign add_b  = is_sub ? ~b : b;
    assign add_c  = is_sub ? ~cin : cin;
    assign sum    = {1'b0, a} + {1'b0, add_b} + {{N{1'b0}}, add_c};

    // One guard bit on the exit side of each shift catches the last bit shifted out;
    // out-of-range amounts fall out naturally (zero fill, or sign fill for AR).
    assign ll_ext = {1'b0, a} << b;
    assign lr_ext = {a, 1'b0} >> b;
    assign ar_ext = $signed({a, 1'b0}) >>> b;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        y_d        = '0;
        cout_d     = 1'b0;
        overflow_d = 1'b0;
        unique case (opcode)
            ADD_OP, SUB_OP: begin
                y_d        = sum[N-1:0];
                cout_d     = sum[N];
                overflow_d = (a[N-1] == add_b[N-1]) && (sum[N-1] != a[N-1]);
            end
            AND_OP:      y_d = a & b;
            OR_OP:       y_d = a | b;
            XOR_OP:      y_d = a ^ b;
            NOT_OP:      y_d = ~a;
            LL_SHIFT_OP: begin
                y_d    = ll_ext[N-1:0];
                cout_d = ll_ext[N];
            end
            LR_SHIFT_OP: begin
                y_d    = lr_ext[N:1];
                cout_d = lr_ext[0];
            end
            AR_SHIFT_OP: begin
                y_d    = ar_ext[N:1];
                cout_d = ar_ext[0];
            end
            default: ;
        endcase
        negative_d = y_d[N-1];
        zero_d     = ~|y_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q        <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            negative_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            y_q        <= y_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
            negative_q <= negative_d;
            zero_q     <= zero_d;
        end
    end

    assign y        = y_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;
    assign negative = negative_q;
    assign zero     = zero_q;

endmodule : alu_unit

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vectors, randomized traffic against an
// arithmetic reference model, latency, mid-cycle reset and cin isolation.
module tb_alu_unit;

    localparam int N = 4;
    localparam int M = 1 << N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   opcode;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] y;
    logic         cout;
    logic         overflow;
    logic         negative;
    logic         zero;

    logic [N+3:0] obs;
    assign obs = {y, cout, overflow, negative, zero};

    int n_cmp = 0;
    int n_err = 0;

    alu_unit #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opcode   (opcode),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .y        (y),
        .cout     (cout),
        .overflow (overflow),
        .negative (negative),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on unsigned/signed interpretations.
    function automatic logic [N+3:0] model(input logic [3:0] op, input logic [N-1:0] av,
                                           input logic [N-1:0] bv, input logic ci);
        int ua, ub, sa, sb, c_in, s, d, r, sh;
        logic c, v;
        ua   = int'(av);
        ub   = int'(bv);
        sa   = (ua >= M / 2) ? ua - M : ua;
        sb   = (ub >= M / 2) ? ub - M : ub;
        c_in = ci ? 1 : 0;
        r    = 0;
        c    = 1'b0;
        v    = 1'b0;
        case (op)
            4'h0: begin
                s = ua + ub + c_in;
                r = s % M;
                c = (s >= M);
                d = sa + sb + c_in;
                v = (d > M / 2 - 1) || (d < -(M / 2));
            end
            4'h1: begin
                s = ua + (M - 1 - ub) + (1 - c_in);
                r = s % M;
                c = (s >= M);
                d = sa - sb - c_in;
                v = (d > M / 2 - 1) || (d < -(M / 2));
            end
            4'h2: r = ua & ub;
            4'h3: r = ua | ub;
            4'h4: r = ua ^ ub;
            4'h5: r = (M - 1) - ua;
            4'h6: begin
                r = (ub < N) ? (ua * (1 << ub)) % M : 0;
                c = (ub >= 1 && ub <= N) ? ((ua >> (N - ub)) & 1) == 1 : 1'b0;
            end
            4'h7: begin
                r = (ub < N) ? ua / (1 << ub) : 0;
                c = (ub >= 1 && ub <= N) ? ((ua >> (ub - 1)) & 1) == 1 : 1'b0;
            end
            4'h8: begin
                sh = (ub < N) ? ub : N;
                r  = (sa >>> sh) & (M - 1);
                if (ub == 0)       c = 1'b0;
                else if (ub >= N)  c = (sa < 0);
                else               c = ((ua >> (ub - 1)) & 1) == 1;
            end
            default: r = 0;
        endcase
        return {r[N-1:0], c, v, r[N-1], (r == 0)};
    endfunction

    typedef struct {
        logic [3:0]   op;
        logic [N-1:0] av;
        logic [N-1:0] bv;
        logic         ci;
        logic [N+3:0] exp;  // {y, cout, overflow, negative, zero}
    } vec_t;

    vec_t vecs[19] = '{
        '{4'h6, 4'b0001, 4'd3, 1'b0, {4'b1000, 4'b0010}},
        '{4'h6, 4'b1000, 4'd1, 1'b0, {4'b0000, 4'b1001}},
        '{4'h7, 4'b1011, 4'd1, 1'b0, {4'b0101, 4'b1000}},
        '{4'h8, 4'b1001, 4'd1, 1'b0, {4'b1100, 4'b1010}},
        '{4'h8, 4'b1110, 4'd1, 1'b0, {4'b1111, 4'b0010}},
        '{4'h5, 4'b1010, 4'b0000, 1'b0, {4'b0101, 4'b0000}},
        '{4'h2, 4'b1010, 4'b0111, 1'b0, {4'b0010, 4'b0000}},
        '{4'h3, 4'b1000, 4'b0100, 1'b0, {4'b1100, 4'b0010}},
        '{4'h4, 4'b1010, 4'b1010, 1'b0, {4'b0000, 4'b0001}},
        '{4'h0, 4'b0111, 4'b0001, 1'b0, {4'b1000, 4'b0110}},
        '{4'h0, 4'b1111, 4'b0001, 1'b0, {4'b0000, 4'b1001}},
        '{4'h1, 4'b0011, 4'b0101, 1'b0, {4'b1110, 4'b0010}},
        '{4'h6, 4'b0001, 4'd4, 1'b0, {4'b0000, 4'b1001}},
        '{4'h6, 4'b1111, 4'd5, 1'b0, {4'b0000, 4'b0001}},
        '{4'h7, 4'b1000, 4'd4, 1'b0, {4'b0000, 4'b1001}},
        '{4'h8, 4'b1000, 4'd7, 1'b0, {4'b1111, 4'b1010}},
        '{4'h8, 4'b1010, 4'd0, 1'b0, {4'b1010, 4'b0010}},
        '{4'h9, 4'b1111, 4'b1111, 1'b1, {4'b0000, 4'b0001}},
        '{4'h1, 4'b0000, 4'b0000, 1'b1, {4'b1111, 4'b0010}}
    };

    task automatic drive(input logic [3:0] op, input logic [N-1:0] av,
                         input logic [N-1:0] bv, input logic ci);
        opcode = op;
        a      = av;
        b      = bv;
        cin    = ci;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(4'h0, 4'b0111, 4'b0001, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_hold: got %b expected %b", obs, {(N + 4){1'b0}});
        end
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs !== model(4'h0, 4'b0111, 4'b0001, 1'b0)) begin
            n_err++;
            $display("FAIL reset_release: got %b expected %b", obs,
                     model(4'h0, 4'b0111, 4'b0001, 1'b0));
        end
    endtask

    task automatic test_directed;
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].av, vecs[i].bv, vecs[i].ci);
            @(posedge clk);
            #1;
            n_cmp++;
            if (obs !== vecs[i].exp) begin
                n_err++;
                $display("FAIL directed[%0d] op=%h a=%b b=%b cin=%b: got %b expected %b",
                         i, vecs[i].op, vecs[i].av, vecs[i].bv, vecs[i].ci, obs, vecs[i].exp);
            end
        end
    endtask

    task automatic test_back_to_back_random;
        logic [3:0]   op;
        logic [N-1:0] av, bv;
        logic         ci;
        logic [N+3:0] exp;
        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            av = N'($urandom);
            bv = N'($urandom);
            ci = 1'($urandom);
            exp = model(op, av, bv, ci);
            drive(op, av, bv, ci);
            @(posedge clk);
            #1;
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL random[%0d] op=%h a=%b b=%b cin=%b: got %b expected %b",
                         i, op, av, bv, ci, obs, exp);
            end
        end
    endtask

    task automatic test_cin_isolation;
        logic [3:0]   op;
        logic [N-1:0] av, bv;
        logic [N+3:0] exp;
        for (int i = 0; i < 40; i++) begin
            op  = 4'($urandom_range(2, 15));
            av  = N'($urandom);
            bv  = N'($urandom);
            exp = model(op, av, bv, 1'b0);
            drive(op, av, bv, 1'bx);
            @(posedge clk);
            #1;
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL cin_x[%0d] op=%h a=%b b=%b: got %b expected %b",
                         i, op, av, bv, obs, exp);
            end
        end
    endtask

    task automatic test_latency;
        logic [N+3:0] exp1, exp2;
        exp1 = model(4'h0, 4'b0111, 4'b0001, 1'b0);
        exp2 = model(4'h4, 4'b1010, 4'b1010, 1'b0);
        drive(4'h0, 4'b0111, 4'b0001, 1'b0);
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs !== exp1) begin
            n_err++;
            $display("FAIL latency_first: got %b expected %b", obs, exp1);
        end
        #3 drive(4'h4, 4'b1010, 4'b1010, 1'b0);
        #1;
        n_cmp++;
        if (obs !== exp1) begin
            n_err++;
            $display("FAIL latency_hold: got %b expected %b", obs, exp1);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs !== exp2) begin
            n_err++;
            $display("FAIL latency_update: got %b expected %b", obs, exp2);
        end
    endtask

    task automatic test_reset_midcycle;
        logic [N+3:0] exp;
        exp = model(4'h0, 4'b0111, 4'b0001, 1'b0);
        drive(4'h0, 4'b0111, 4'b0001, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_async: got %b expected %b", obs, {(N + 4){1'b0}});
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_edge_hold: got %b expected %b", obs, {(N + 4){1'b0}});
        end
        #2 rst_n = 1'b1;
        #1;
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_until_edge: got %b expected %b", obs, {(N + 4){1'b0}});
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL reset_resume: got %b expected %b", obs, exp);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back_random();
        test_cin_isolation();
        test_latency();
        test_reset_midcycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu_unit
